sram_arb: RTL and testbench
===========================

# sram_arb

Two-port arbiter and sequencer for the board's single asynchronous 16-bit SRAM (256K words). It replaces the wired OR/AND merging of the SRAM pins between the core memory (`core161c`, port 0) and the I2C loader (`i2c_core`, port 1). Each access is a registered, fixed-length cycle with a req/ack handshake and round-robin fairness, so that neither requester can corrupt the other's cycle.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: cycles `sram_ce` stays asserted with the strobe active (minimum 1).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `pN_req`  in  1  port N (N = 0, 1) access request; level; held until `pN_ack`.
- `pN_we`  in  1  1 = write, 0 = read; sampled at grant.
- `pN_addr`  in  18  word address; sampled at grant.
- `pN_wdata`  in  16  write data; sampled at grant.
- `pN_lb`  in  1  low-byte enable, active-high; sampled at grant.
- `pN_ub`  in  1  high-byte enable, active-high; sampled at grant.
- `pN_ack`  out  1  one-cycle completion pulse.
- `pN_rdata`  out  16  read data; valid with `pN_ack`, held until that port's next ack.
- `sram_a`  out  18  SRAM address, registered.
- `sram_d`  inout  16  SRAM data; driven only during write cycles.
- `sram_ce`  out  1  chip enable, active-low.
- `sram_oe`  out  1  output enable, active-low.
- `sram_we`  out  1  write enable, active-low.
- `sram_lb`  out  1  low-byte strobe, active-low.
- `sram_ub`  out  1  high-byte strobe, active-low.
- `busy`  out  1  high in ACCESS and END.
- `owner`  out  1  port being served; 0 when idle.

## Operation
- FSM states: IDLE, ACCESS, END. All outputs are registered.
- **IDLE.** If no request is pending, stay. With exactly one `pN_req`, grant that port. With both requesting, grant the port not served last. The last-served pointer resets to 1, so port 0 wins the first tie. On grant, latch we/addr/wdata/lb/ub, set `owner`, and go to ACCESS with counter = `WAIT_CYCLES`-1.
- **ACCESS.**
  - `sram_a` = latched address.
  - `sram_ce` = 0; `sram_lb`/`sram_ub` = inverse of the latched enables.
  - Read: `sram_oe` = 0, `sram_we` = 1, `sram_d` = Z.
  - Write: `sram_we` = 0, `sram_oe` = 1, `sram_d` driven with latched wdata.
  - Decrement the counter. At 0: for reads, capture `sram_d` into the owner's rdata; go to END.
- **END.**
  - `sram_ce`, `sram_oe`, `sram_we`, `sram_lb`, `sram_ub` = 1.
  - For writes, `sram_d` stays driven this cycle as data hold time, then tristates on exit.
  - `sram_a` holds.
  - Pulse `pN_ack` for the owner; update the last-served pointer; go to IDLE.
- Deasserting `pN_req` during ACCESS/END does not abort. The cycle completes and ack still pulses.
- A requester must drop `req` on the edge where it samples ack. A `req` still high in the following IDLE cycle starts a new access.
- Byte enables both 0: the cycle runs with `sram_lb`=`sram_ub`=1 and completes normally. rdata captures the bus value unchanged (don't-care content).

## Timing
- Reset (asynchronous) values:
  - State IDLE.
  - `sram_ce`, `sram_oe`, `sram_we`, `sram_lb`, `sram_ub` = 1; `sram_a` = 0; `sram_d` = Z.
  - `p0_ack`, `p1_ack`, `busy`, `owner` = 0; rdata = 0; last-served = 1.
- Reset mid-cycle: strobes deassert immediately (asynchronously), no ack is issued, and the requester must reissue.
- Latency: with `req` sampled high in IDLE at edge T, ACCESS occupies T+1..T+`WAIT_CYCLES`, END is T+`WAIT_CYCLES`+1, and ack is visible in that cycle.
- Back-to-back throughput: one access per `WAIT_CYCLES`+2 cycles. The IDLE cycle is the bus-turnaround gap.
- `sram_oe` and `sram_we` are never both 0. `sram_d` is never driven while `sram_oe`=0.

## Structure
- Package `sram_arb_pkg`: state encoding (IDLE, ACCESS, END), port-index constants (`PORT_CORE`=0, `PORT_I2C`=1), SRAM widths (address 18, data 16).
- One sub-module, `sram_pins`: output registers for the SRAM pins plus the tristate buffer and read capture register. The FSM and arbitration live in `sram_arb`.

## Test plan
- Single read, `WAIT_CYCLES`=2:
  - Stimulus: p0 reads address 0x00123 with the SRAM model returning 0xBEEF.
  - Required: `sram_ce`/`sram_oe` low for exactly 2 cycles, `p0_ack` pulses 3 cycles after grant, `p0_rdata` = 0xBEEF.
- Write with byte mask:
  - Stimulus: p1 writes 0x1234 to 0x3FFFF with ub=1, lb=0.
  - Required: `sram_ub`=0, `sram_lb`=1, `sram_we` low 2 cycles, `sram_d`=0x1234 through END, then Z. The model holds high byte 0x12 and an unchanged low byte.
- Tie after reset: p0 and p1 raise req in the same cycle and keep re-requesting. Required: grants alternate 0,1,0,1; each ack goes only to the owner.
- Starvation check: p0 requests continuously and p1 requests once. Required: p1 is granted no later than the second grant after its request.
- Abandoned request: p0 drops req during ACCESS. Required: the cycle completes and `p0_ack` still pulses once.
- Reset mid-write: assert `reset` during ACCESS. Required: all strobes = 1 and `sram_d` = Z in the same cycle, no ack, and the next request completes normally.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Holds the FSM encoding, port indices, SRAM widths and the round-robin pick rule.
package sram_arb_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_I2C  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_END    = 2'd2
  } state_t;

  // On a tie the port not served last wins; otherwise the single requester wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1 ? PORT_I2C : PORT_CORE;
  endfunction

endpackage

// File: rtl/sram_pins.sv
// SRAM pin output registers, data tristate driver and per-port read capture.
// Every pin value is computed by the sequencer one cycle ahead and registered here.
module sram_pins
  import sram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_a_ld,
  input  logic [SRAM_AW-1:0] i_a,
  input  logic               i_ce_n,
  input  logic               i_oe_n,
  input  logic               i_we_n,
  input  logic               i_lb_n,
  input  logic               i_ub_n,
  input  logic               i_d_oe,
  input  logic [SRAM_DW-1:0] i_d,
  input  logic               i_cap0,
  input  logic               i_cap1,
  output logic [SRAM_AW-1:0] o_sram_a,
  inout  wire  [SRAM_DW-1:0] io_sram_d,
  output logic               o_sram_ce,
  output logic               o_sram_oe,
  output logic               o_sram_we,
  output logic               o_sram_lb,
  output logic               o_sram_ub,
  output logic [SRAM_DW-1:0] o_rdata0,
  output logic [SRAM_DW-1:0] o_rdata1
);

  logic [SRAM_AW-1:0] r_a;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic               r_lb_n;
  logic               r_ub_n;
  logic               r_d_oe;
  logic [SRAM_DW-1:0] r_dout;
  logic [SRAM_DW-1:0] r_rdata0;
  logic [SRAM_DW-1:0] r_rdata1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_lb_n   <= 1'b1;
      r_ub_n   <= 1'b1;
      r_d_oe   <= 1'b0;
      r_dout   <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (i_a_ld) begin
        r_a <= i_a;
      end
      r_ce_n <= i_ce_n;
      r_oe_n <= i_oe_n;
      r_we_n <= i_we_n;
      r_lb_n <= i_lb_n;
      r_ub_n <= i_ub_n;
      r_d_oe <= i_d_oe;
      r_dout <= i_d;
      // Capture happens on the edge that closes the last ACCESS cycle, while OE is still low.
      if (i_cap0) begin
        r_rdata0 <= io_sram_d;
      end
      if (i_cap1) begin
        r_rdata1 <= io_sram_d;
      end
    end
  end

  assign io_sram_d = r_d_oe ? r_dout : {SRAM_DW{1'bz}};

  assign o_sram_a  = r_a;
  assign o_sram_ce = r_ce_n;
  assign o_sram_oe = r_oe_n;
  assign o_sram_we = r_we_n;
  assign o_sram_lb = r_lb_n;
  assign o_sram_ub = r_ub_n;
  assign o_rdata0  = r_rdata0;
  assign o_rdata1  = r_rdata1;

endmodule

// File: rtl/sram_arb.sv
// Round-robin arbiter and fixed-length access sequencer for one async 16-bit SRAM.
// Grant edge T: ACCESS for WAIT_CYCLES cycles, END (ack) after edge T+WAIT_CYCLES, IDLE gap follows.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p0_req,
  input  logic               p0_we,
  input  logic [SRAM_AW-1:0] p0_addr,
  input  logic [SRAM_DW-1:0] p0_wdata,
  input  logic               p0_lb,
  input  logic               p0_ub,
  output logic               p0_ack,
  output logic [SRAM_DW-1:0] p0_rdata,
  input  logic               p1_req,
  input  logic               p1_we,
  input  logic [SRAM_AW-1:0] p1_addr,
  input  logic [SRAM_DW-1:0] p1_wdata,
  input  logic               p1_lb,
  input  logic               p1_ub,
  output logic               p1_ack,
  output logic [SRAM_DW-1:0] p1_rdata,
  output logic [SRAM_AW-1:0] sram_a,
  inout  wire  [SRAM_DW-1:0] sram_d,
  output logic               sram_ce,
  output logic               sram_oe,
  output logic               sram_we,
  output logic               sram_lb,
  output logic               sram_ub,
  output logic               busy,
  output logic               owner
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_we;
  logic [SRAM_DW-1:0] r_wdata;
  logic               r_lb;
  logic               r_ub;
  logic               r_owner;
  logic               r_last;
  logic               r_busy;
  logic               r_ack0;
  logic               r_ack1;

  state_t             w_state_nx;
  logic [CW-1:0]      w_cnt_nx;
  logic               w_we_nx;
  logic [SRAM_DW-1:0] w_wdata_nx;
  logic               w_lb_nx;
  logic               w_ub_nx;
  logic               w_owner_nx;
  logic               w_last_nx;
  logic               w_busy_nx;
  logic               w_ack0_nx;
  logic               w_ack1_nx;

  logic               w_pick;
  logic               w_sel_we;
  logic [SRAM_AW-1:0] w_sel_addr;
  logic [SRAM_DW-1:0] w_sel_wdata;
  logic               w_sel_lb;
  logic               w_sel_ub;

  logic               w_a_ld;
  logic               w_ce_n;
  logic               w_oe_n;
  logic               w_we_n;
  logic               w_lb_n;
  logic               w_ub_n;
  logic               w_d_oe;
  logic               w_cap0;
  logic               w_cap1;

  assign w_pick      = rr_pick(p0_req, p1_req, r_last);
  assign w_sel_we    = w_pick ? p1_we    : p0_we;
  assign w_sel_addr  = w_pick ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_pick ? p1_wdata : p0_wdata;
  assign w_sel_lb    = w_pick ? p1_lb    : p0_lb;
  assign w_sel_ub    = w_pick ? p1_ub    : p0_ub;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_lb    <= 1'b0;
      r_ub    <= 1'b0;
      r_owner <= PORT_CORE;
      r_last  <= PORT_I2C;
      r_busy  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_we    <= w_we_nx;
      r_wdata <= w_wdata_nx;
      r_lb    <= w_lb_nx;
      r_ub    <= w_ub_nx;
      r_owner <= w_owner_nx;
      r_last  <= w_last_nx;
      r_busy  <= w_busy_nx;
      r_ack0  <= w_ack0_nx;
      r_ack1  <= w_ack1_nx;
    end
  end

  // Next-state logic also produces the pin values for the following cycle.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_we_nx    = r_we;
    w_wdata_nx = r_wdata;
    w_lb_nx    = r_lb;
    w_ub_nx    = r_ub;
    w_owner_nx = r_owner;
    w_last_nx  = r_last;
    w_busy_nx  = r_busy;
    w_ack0_nx  = 1'b0;
    w_ack1_nx  = 1'b0;
    w_a_ld     = 1'b0;
    w_ce_n     = 1'b1;
    w_oe_n     = 1'b1;
    w_we_n     = 1'b1;
    w_lb_n     = 1'b1;
    w_ub_n     = 1'b1;
    w_d_oe     = 1'b0;
    w_cap0     = 1'b0;
    w_cap1     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (p0_req || p1_req) begin
          w_state_nx = ST_ACCESS;
          w_cnt_nx   = CNT_INIT;
          w_owner_nx = w_pick;
          w_busy_nx  = 1'b1;
          w_we_nx    = w_sel_we;
          w_wdata_nx = w_sel_wdata;
          w_lb_nx    = w_sel_lb;
          w_ub_nx    = w_sel_ub;
          w_a_ld     = 1'b1;
          w_ce_n     = 1'b0;
          w_oe_n     = w_sel_we;
          w_we_n     = ~w_sel_we;
          w_lb_n     = ~w_sel_lb;
          w_ub_n     = ~w_sel_ub;
          w_d_oe     = w_sel_we;
        end
      end

      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nx = ST_END;
          // Writes keep driving through END for data hold after WE rises.
          w_d_oe     = r_we;
          w_cap0     = ~r_we && (r_owner == PORT_CORE);
          w_cap1     = ~r_we && (r_owner == PORT_I2C);
          w_ack0_nx  = (r_owner == PORT_CORE);
          w_ack1_nx  = (r_owner == PORT_I2C);
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
          w_ce_n   = 1'b0;
          w_oe_n   = r_we;
          w_we_n   = ~r_we;
          w_lb_n   = ~r_lb;
          w_ub_n   = ~r_ub;
          w_d_oe   = r_we;
        end
      end

      ST_END: begin
        w_state_nx = ST_IDLE;
        w_busy_nx  = 1'b0;
        w_owner_nx = PORT_CORE;
        w_last_nx  = r_owner;
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  sram_pins u_pins (
    .clk       (clk),
    .reset     (reset),
    .i_a_ld    (w_a_ld),
    .i_a       (w_sel_addr),
    .i_ce_n    (w_ce_n),
    .i_oe_n    (w_oe_n),
    .i_we_n    (w_we_n),
    .i_lb_n    (w_lb_n),
    .i_ub_n    (w_ub_n),
    .i_d_oe    (w_d_oe),
    .i_d       (w_wdata_nx),
    .i_cap0    (w_cap0),
    .i_cap1    (w_cap1),
    .o_sram_a  (sram_a),
    .io_sram_d (sram_d),
    .o_sram_ce (sram_ce),
    .o_sram_oe (sram_oe),
    .o_sram_we (sram_we),
    .o_sram_lb (sram_lb),
    .o_sram_ub (sram_ub),
    .o_rdata0  (p0_rdata),
    .o_rdata1  (p1_rdata)
  );

  assign p0_ack = r_ack0;
  assign p1_ack = r_ack1;
  assign busy   = r_busy;
  assign owner  = r_owner;

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: directed vector table, multi-cycle corner sequences and a
// randomized two-requester run checked against a cycle-count/shadow-memory model.
module tb_sram_arb;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_lb, p0_ub;
  logic [17:0] p0_addr;
  logic [15:0] p0_wdata;
  logic        p0_ack;
  logic [15:0] p0_rdata;
  logic        p1_req, p1_we, p1_lb, p1_ub;
  logic [17:0] p1_addr;
  logic [15:0] p1_wdata;
  logic        p1_ack;
  logic [15:0] p1_rdata;
  logic [17:0] sram_a;
  wire  [15:0] sram_d;
  logic        sram_ce, sram_oe, sram_we, sram_lb, sram_ub;
  logic        busy, owner;

  int checks = 0;
  int failures = 0;

  sram_arb #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_lb(p0_lb), .p0_ub(p0_ub), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lb(p1_lb), .p1_ub(p1_ub), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .sram_a(sram_a), .sram_d(sram_d), .sram_ce(sram_ce), .sram_oe(sram_oe),
    .sram_we(sram_we), .sram_lb(sram_lb), .sram_ub(sram_ub),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: drives the bus on reads, latches masked bytes while WE is low.
  logic [15:0] mem [0:262143];
  wire  [15:0] w_mem_rd = mem[sram_a];
  assign sram_d = (!sram_ce && !sram_oe && sram_we) ? w_mem_rd : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_ce && !sram_we) begin
      if (!sram_lb) mem[sram_a][7:0]  <= sram_d[7:0];
      if (!sram_ub) mem[sram_a][15:8] <= sram_d[15:8];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((!sram_oe && !sram_we) || (p0_ack && p1_ack)) begin
        failures++;
        $display("FAIL bus_invariant oe=%b we=%b ack0=%b ack1=%b required no oe/we overlap, one ack",
                 sram_oe, sram_we, p0_ack, p1_ack);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Released bus reads Z in 4-state simulators and 0 in 2-state ones.
  function automatic logic released(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input logic p, input logic req, input logic we, input logic [17:0] a,
                          input logic [15:0] wd, input logic lb, input logic ub);
    if (p) begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = wd; p1_lb = lb; p1_ub = ub;
    end else begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = wd; p0_lb = lb; p0_ub = ub;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic run_one(input logic port, input logic we, input logic [17:0] addr,
                         input logic [15:0] wd, input logic lb, input logic ub,
                         output int lat, output logic [15:0] rd, output int ce_n,
                         output int oe_n, output int we_n, output logic [1:0] strb,
                         output logic [17:0] a_seen, output logic [15:0] d_end,
                         output logic d_rel_after, output int wrong_ack);
    lat = -1; rd = '0; ce_n = 0; oe_n = 0; we_n = 0; strb = 2'b11; a_seen = '0;
    d_end = '0; d_rel_after = 1'b0; wrong_ack = 0;
    set_port(port, 1'b1, we, addr, wd, lb, ub);
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (!sram_ce) begin
        ce_n++;
        strb = {sram_ub, sram_lb};
        a_seen = sram_a;
      end
      if (!sram_oe) oe_n++;
      if (!sram_we) we_n++;
      if (port ? p0_ack : p1_ack) wrong_ack++;
      if (port ? p1_ack : p0_ack) begin
        lat = c;
        rd = port ? p1_rdata : p0_rdata;
        d_end = sram_d;
        break;
      end
    end
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
    tick;
    d_rel_after = released(sram_d);
    if (p0_ack || p1_ack) wrong_ack++;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [17:0] addr;
    logic [15:0] wd;
    logic        lb;
    logic        ub;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, ce_n, oe_n, we_n, wrong_ack, acks, cnt;
    logic [15:0] rd, d_end;
    logic [1:0] strb;
    logic [17:0] a_seen;
    logic d_rel;
    int grants [$];

    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    mem[18'h00123] = 16'hBEEF;
    mem[18'h3FFFF] = 16'hABCD;
    set_port(1'b0, 1'b0, 1'b0, 18'h0, 16'h0, 1'b1, 1'b1);
    set_port(1'b1, 1'b0, 1'b0, 18'h0, 16'h0, 1'b1, 1'b1);

    // ---------------- reset state
    reset = 1'b1;
    #3;
    chk("rst_strobes", {27'd0, sram_ce, sram_oe, sram_we, sram_lb, sram_ub}, 32'h1F);
    chk("rst_addr", {14'd0, sram_a}, 32'h0);
    chk("rst_ack_busy_owner", {28'd0, p0_ack, p1_ack, busy, owner}, 32'h0);
    chk("rst_rdata", {p1_rdata, p0_rdata}, 32'h0);
    chk("rst_d_released", {31'd0, released(sram_d)}, 32'h1);
    tick;
    tick;
    reset = 1'b0;
    tick;

    // ---------------- vector table
    vecs[0] = '{1'b0, 1'b0, 18'h00123, 16'h0000, 1'b1, 1'b1, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 18'h3FFFF, 16'h1234, 1'b0, 1'b1, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 18'h3FFFF, 16'h0000, 1'b1, 1'b1, 16'h12CD};
    vecs[3] = '{1'b1, 1'b1, 18'h00010, 16'h5678, 1'b1, 1'b1, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 18'h00010, 16'h0000, 1'b1, 1'b1, 16'h5678};
    vecs[5] = '{1'b0, 1'b1, 18'h00010, 16'h9ABC, 1'b0, 1'b0, 16'h12CD};
    vecs[6] = '{1'b0, 1'b0, 18'h00010, 16'h0000, 1'b1, 1'b1, 16'h5678};
    vecs[7] = '{1'b1, 1'b0, 18'h00123, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].lb, vecs[i].ub,
              lat, rd, ce_n, oe_n, we_n, strb, a_seen, d_end, d_rel, wrong_ack);
      chk($sformatf("vec%0d_ack_latency", i), lat, W + 1);
      chk($sformatf("vec%0d_ce_low", i), ce_n, W);
      chk($sformatf("vec%0d_oe_low", i), oe_n, vecs[i].we ? 0 : W);
      chk($sformatf("vec%0d_we_low", i), we_n, vecs[i].we ? W : 0);
      chk($sformatf("vec%0d_strobes_ub_lb", i), {30'd0, strb}, {30'd0, ~vecs[i].ub, ~vecs[i].lb});
      chk($sformatf("vec%0d_addr", i), {14'd0, a_seen}, {14'd0, vecs[i].addr});
      chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rd});
      if (vecs[i].we) chk($sformatf("vec%0d_d_hold_end", i), {16'd0, d_end}, {16'd0, vecs[i].wd});
      else            chk($sformatf("vec%0d_d_free_end", i), {31'd0, released(d_end)}, 32'h1);
      chk($sformatf("vec%0d_d_released_after", i), {31'd0, d_rel}, 32'h1);
      chk($sformatf("vec%0d_stray_ack", i), wrong_ack, 0);
    end
    chk("mem_masked_write", {16'd0, mem[18'h3FFFF]}, 32'h12CD);
    chk("rdata_hold_both", {p1_rdata, p0_rdata}, {16'hBEEF, 16'h5678});

    // ---------------- tie after reset, alternating grants
    do_reset;
    set_port(1'b0, 1'b1, 1'b0, 18'h00123, 16'h0, 1'b1, 1'b1);
    set_port(1'b1, 1'b1, 1'b0, 18'h3FFFF, 16'h0, 1'b1, 1'b1);
    begin
      logic re0, re1;
      re0 = 1'b0; re1 = 1'b0;
      grants.delete();
      for (int c = 0; c < 60 && grants.size() < 4; c++) begin
        tick;
        if (re0) begin p0_req = 1'b1; re0 = 1'b0; end
        if (re1) begin p1_req = 1'b1; re1 = 1'b0; end
        if (p0_ack || p1_ack) begin
          chk("tie_ack_to_owner", {31'd0, p1_ack}, {31'd0, owner});
          grants.push_back(p1_ack ? 1 : 0);
          if (p0_ack) begin p0_req = 1'b0; re0 = 1'b1; end
          if (p1_ack) begin p1_req = 1'b0; re1 = 1'b1; end
        end
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    chk("tie_grant_count", grants.size(), 4);
    for (int k = 0; k < grants.size(); k++) chk($sformatf("tie_grant%0d", k), grants[k], k % 2);
    chk("tie_rdata", {p1_rdata, p0_rdata}, {16'h12CD, 16'hBEEF});
    tick;
    tick;

    // ---------------- starvation: p0 continuous, p1 requests once mid-access
    do_reset;
    set_port(1'b0, 1'b1, 1'b0, 18'h00010, 16'h0, 1'b1, 1'b1);
    tick;
    set_port(1'b1, 1'b1, 1'b0, 18'h00123, 16'h0, 1'b1, 1'b1);
    grants.delete();
    begin
      logic re0;
      re0 = 1'b0;
      for (int c = 0; c < 60 && grants.size() < 3; c++) begin
        tick;
        if (re0) begin p0_req = 1'b1; re0 = 1'b0; end
        if (p0_ack) begin grants.push_back(0); p0_req = 1'b0; re0 = 1'b1; end
        if (p1_ack) begin grants.push_back(1); p1_req = 1'b0; end
      end
    end
    p0_req = 1'b0;
    chk("starve_grant_count", grants.size(), 3);
    cnt = 99;
    for (int k = 0; k < grants.size(); k++) if (grants[k] == 1 && cnt == 99) cnt = k;
    chk("starve_p1_within_two", {31'd0, cnt <= 1}, 32'h1);
    chk("starve_p1_rdata", {16'd0, p1_rdata}, 32'hBEEF);
    tick;
    tick;
    tick;

    // ---------------- abandoned request
    set_port(1'b0, 1'b1, 1'b0, 18'h00010, 16'h0, 1'b1, 1'b1);
    tick;
    p0_req = 1'b0;
    acks = (p0_ack ? 1 : 0);
    ce_n = (!sram_ce) ? 1 : 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (p0_ack) acks++;
      if (!sram_ce) ce_n++;
    end
    chk("abandon_ack_once", acks, 1);
    chk("abandon_ce_low", ce_n, W);
    chk("abandon_rdata", {16'd0, p0_rdata}, 32'h5678);

    // ---------------- reset mid-write
    set_port(1'b1, 1'b1, 1'b1, 18'h00020, 16'h1234, 1'b1, 1'b1);
    tick;
    chk("midrst_we_active", {31'd0, sram_we}, 32'h0);
    #3;
    reset = 1'b1;
    p1_req = 1'b0;
    #1;
    chk("midrst_strobes", {27'd0, sram_ce, sram_oe, sram_we, sram_lb, sram_ub}, 32'h1F);
    chk("midrst_d_released", {31'd0, released(sram_d)}, 32'h1);
    chk("midrst_no_ack", {30'd0, p0_ack, p1_ack}, 32'h0);
    tick;
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (p0_ack || p1_ack) acks++;
    end
    chk("midrst_no_late_ack", acks, 0);
    run_one(1'b1, 1'b0, 18'h00010, 16'h0, 1'b1, 1'b1,
            lat, rd, ce_n, oe_n, we_n, strb, a_seen, d_end, d_rel, wrong_ack);
    chk("midrst_after_latency", lat, W + 1);
    chk("midrst_after_rdata", {16'd0, rd}, 32'h5678);

    // ---------------- randomized two-requester run
    do_reset;
    begin
      logic [15:0] shadow [16];
      logic [15:0] rd_hold [2];
      int gap [2];
      int e, next_free, ack_edge;
      logic pend, exp_owner, exp_we, m_last, win, r0, r1;
      logic [15:0] exp_rd;
      for (int i = 0; i < 16; i++) shadow[i] = mem[18'h00200 + 18'(i)];
      rd_hold[0] = 16'h0; rd_hold[1] = 16'h0;
      gap[0] = $urandom_range(0, 3); gap[1] = $urandom_range(0, 3);
      e = 0; next_free = 1; ack_edge = -1; pend = 1'b0; m_last = 1'b1;
      exp_owner = 1'b0; exp_we = 1'b0; exp_rd = '0;
      for (int c = 0; c < 1500; c++) begin
        tick;
        e++;
        if (pend && e == ack_edge) begin
          chk("rand_ack0", {31'd0, p0_ack}, {31'd0, exp_owner == 1'b0});
          chk("rand_ack1", {31'd0, p1_ack}, {31'd0, exp_owner == 1'b1});
          if (!exp_we) rd_hold[exp_owner] = exp_rd;
          pend = 1'b0;
          if (exp_owner) p1_req = 1'b0; else p0_req = 1'b0;
          gap[exp_owner] = $urandom_range(1, 3);
        end else begin
          chk("rand_no_ack", {30'd0, p0_ack, p1_ack}, 32'h0);
        end
        chk("rand_rdata0", {16'd0, p0_rdata}, {16'd0, rd_hold[0]});
        chk("rand_rdata1", {16'd0, p1_rdata}, {16'd0, rd_hold[1]});
        for (int p = 0; p < 2; p++) begin
          if (!(p ? p1_req : p0_req)) begin
            if (gap[p] == 0) set_port(p[0], 1'b1, 1'($urandom_range(0, 1)),
                                      18'h00200 + 18'($urandom_range(0, 15)),
                                      16'($urandom), 1'($urandom_range(0, 1)),
                                      1'($urandom_range(0, 1)));
            else gap[p]--;
          end
        end
        r0 = p0_req; r1 = p1_req;
        if (!pend && (e + 1) >= next_free && (r0 || r1)) begin
          win = (r0 && r1) ? ~m_last : r1;
          m_last = win;
          pend = 1'b1;
          exp_owner = win;
          ack_edge = e + 1 + W;
          next_free = e + 1 + W + 2;
          exp_we = win ? p1_we : p0_we;
          begin
            int idx;
            logic [15:0] wd;
            logic lb, ub;
            idx = int'((win ? p1_addr : p0_addr) - 18'h00200);
            wd = win ? p1_wdata : p0_wdata;
            lb = win ? p1_lb : p0_lb;
            ub = win ? p1_ub : p0_ub;
            exp_rd = shadow[idx];
            if (exp_we && lb) shadow[idx][7:0] = wd[7:0];
            if (exp_we && ub) shadow[idx][15:8] = wd[15:8];
          end
        end
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
      for (int c = 0; c < 6; c++) tick;
      for (int i = 0; i < 16; i++)
        chk($sformatf("rand_mem%0d", i), {16'd0, mem[18'h00200 + 18'(i)]}, {16'd0, shadow[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
